// File: rtl/mono_line_buffer_ctrl.sv
// Ping-pong line buffer controller for monochrome scanout.
// One bank fills by 32-bit words while the other streams out 1 pixel/clk.
module mono_line_buffer_ctrl #(
  parameter int WORDS_PER_LINE = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        line_start,
  output logic        pixel,
  output logic        pixel_valid,
  output logic        busy,
  output logic        fill_full,
  output logic        underrun,
  output logic [13:0] ram_addra,
  output logic        ram_ena,
  output logic        ram_wea,
  input  logic        ram_doa,
  output logic [8:0]  ram_addrb,
  output logic [31:0] ram_dib,
  output logic        ram_enb,
  output logic        ram_web
);

  localparam int PIXELS = WORDS_PER_LINE * 32;
  localparam logic [7:0] LAST_WORD =
    8'(WORDS_PER_LINE - 1);
  localparam logic [12:0] LAST_BIT =
    13'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        fill_bank;
  logic        disp_bank;
  logic [7:0]  fill_cnt;
  logic [12:0] bit_cnt;
  logic [12:0] bit_cnt_nx;
  logic        full_q;
  logic        under_q;
  logic        pv_q;
  logic        scan_en;
  logic        accept;
  logic        start;
  logic        swap;

  // The display bank is always the one not being filled.
  assign disp_bank = ~fill_bank;

  assign accept = word_valid & ~full_q;
  assign start  = line_start & (state == IDLE);
  assign swap   = start & full_q;

  assign word_ready = ~full_q;
  assign fill_full  = full_q;
  assign underrun   = under_q;

  assign ram_addrb = {fill_bank, fill_cnt};
  assign ram_dib   = word_data;
  assign ram_enb   = accept;
  assign ram_web   = accept;

  assign ram_addra = {disp_bank, bit_cnt};
  assign ram_ena   = scan_en;
  assign ram_wea   = 1'b0;

  assign pixel       = ram_doa;
  assign pixel_valid = pv_q;
  assign busy        = (state != IDLE);

  // Fill side: word counter, full flag and bank swap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_bank <= 1'b0;
      fill_cnt  <= '0;
      full_q    <= 1'b0;
    end else if (swap) begin
      fill_bank <= ~fill_bank;
      fill_cnt  <= '0;
      full_q    <= 1'b0;
    end else if (accept) begin
      fill_cnt <= fill_cnt + 8'd1;
      if (fill_cnt == LAST_WORD) begin
        full_q <= 1'b1;
      end
    end
  end

  // Sticky underrun when a line starts on an incomplete fill bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      under_q <= 1'b0;
    end else if (start && !full_q) begin
      under_q <= 1'b1;
    end
  end

  // Scan state, bit counter and read-latency-matched valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pv_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      pv_q    <= scan_en;
    end
  end

  // Scan next-state and port A enable.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    scan_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx   = SCAN;
          bit_cnt_nx = '0;
        end
      end
      SCAN: begin
        scan_en    = 1'b1;
        bit_cnt_nx = bit_cnt + 13'd1;
        if (bit_cnt == LAST_BIT) begin
          state_nx   = DRAIN;
          bit_cnt_nx = '0;
        end
      end
      DRAIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mono_line_buffer_ctrl.sv
// Scoreboard bench for mono_line_buffer_ctrl.
// Main instance at 20 words/line, second at 1 word/line.
module tb_mono_line_buffer_ctrl;

  localparam int W   = 20;
  localparam int PIX = W * 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        line_start;
  logic        pixel;
  logic        pixel_valid;
  logic        busy;
  logic        fill_full;
  logic        underrun;
  logic [13:0] ram_addra;
  logic        ram_ena;
  logic        ram_wea;
  logic        ram_doa;
  logic [8:0]  ram_addrb;
  logic [31:0] ram_dib;
  logic        ram_enb;
  logic        ram_web;

  logic [31:0] b_word_data;
  logic        b_word_valid;
  logic        b_word_ready;
  logic        b_line_start;
  logic        b_pixel;
  logic        b_pixel_valid;
  logic        b_busy;
  logic        b_fill_full;
  logic        b_underrun;
  logic [13:0] b_ram_addra;
  logic        b_ram_ena;
  logic        b_ram_wea;
  logic        b_ram_doa;
  logic [8:0]  b_ram_addrb;
  logic [31:0] b_ram_dib;
  logic        b_ram_enb;
  logic        b_ram_web;

  mono_line_buffer_ctrl #(.WORDS_PER_LINE(W)) dut (
    .clock(clock), .reset(reset),
    .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .line_start(line_start),
    .pixel(pixel), .pixel_valid(pixel_valid),
    .busy(busy), .fill_full(fill_full),
    .underrun(underrun), .ram_addra(ram_addra),
    .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_doa(ram_doa), .ram_addrb(ram_addrb),
    .ram_dib(ram_dib), .ram_enb(ram_enb),
    .ram_web(ram_web)
  );

  mono_line_buffer_ctrl #(.WORDS_PER_LINE(1)) dut_b (
    .clock(clock), .reset(reset),
    .word_data(b_word_data), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .line_start(b_line_start),
    .pixel(b_pixel), .pixel_valid(b_pixel_valid),
    .busy(b_busy), .fill_full(b_fill_full),
    .underrun(b_underrun), .ram_addra(b_ram_addra),
    .ram_ena(b_ram_ena), .ram_wea(b_ram_wea),
    .ram_doa(b_ram_doa), .ram_addrb(b_ram_addrb),
    .ram_dib(b_ram_dib), .ram_enb(b_ram_enb),
    .ram_web(b_ram_web)
  );

  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];

  always @(posedge clock) begin
    if (ram_enb && ram_web) mem_a[ram_addrb] <= ram_dib;
    if (ram_ena) ram_doa <= mem_a[ram_addra[13:5]][ram_addra[4:0]];
  end

  always @(posedge clock) begin
    if (b_ram_enb && b_ram_web) mem_b[b_ram_addrb] <= b_ram_dib;
    if (b_ram_ena) b_ram_doa <= mem_b[b_ram_addra[13:5]][b_ram_addra[4:0]];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  logic [40:0] wq [$];
  logic        pq [$];
  logic [13:0] aq [$];
  int          wr_seen = 0;
  int          pix_seen = 0;
  int          line_base = 0;
  logic [31:0] first32;

  always @(negedge clock) begin : mon
    logic [40:0] e;
    logic        p;
    int          idx;
    if (!reset) begin
      if (ram_enb || ram_web) begin
        if (wq.size() == 0) begin
          chk("write_unexpected", {30'b0, ram_enb, ram_web}, 32'h0);
        end else begin
          e = wq.pop_front();
          chk("write_addr", {23'b0, ram_addrb}, {23'b0, e[40:32]});
          chk("write_data", ram_dib, e[31:0]);
          chk("write_en", {30'b0, ram_enb, ram_web}, 32'h3);
          wr_seen++;
        end
      end
      if (ram_ena) begin
        if (aq.size() == 0)
          chk("read_unexpected", {31'b0, ram_ena}, 32'h0);
        else
          chk("read_addr", {18'b0, ram_addra}, {18'b0, aq.pop_front()});
      end
      if (pixel_valid) begin
        if (pq.size() == 0) begin
          chk("pixel_unexpected", {31'b0, pixel_valid}, 32'h0);
        end else begin
          p = pq.pop_front();
          chk("pixel", {31'b0, pixel}, {31'b0, p});
          idx = pix_seen - line_base;
          if (idx < 32) first32[idx] = pixel;
          pix_seen++;
        end
      end
    end
  end

  logic [31:0] bm [0:1][0:255];
  logic        fb;
  int          fc;
  logic        ff;
  logic        und;

  task automatic write_words(input int n, input logic [31:0] base);
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      word_valid = 1'b1;
      word_data  = base ^ 32'(i);
      if (!ff) begin
        wq.push_back({fb, fc[7:0], word_data});
        bm[fb][fc] = word_data;
        fc++;
        if (fc == W) ff = 1'b1;
      end
      @(posedge clock); #1;
    end
    word_valid = 1'b0;
  endtask

  task automatic start_line();
    logic disp;
    @(posedge clock); #1;
    if (ff) begin
      fb = ~fb;
      fc = 0;
      ff = 1'b0;
    end else begin
      und = 1'b1;
    end
    disp = ~fb;
    for (int k = 0; k < PIX; k++) begin
      pq.push_back(bm[disp][k / 32][k % 32]);
      aq.push_back({disp, 13'(k)});
    end
    line_base  = pix_seen;
    line_start = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
  endtask

  task automatic run_scan(input int ls1, input int ls2,
                          input int rst_at, output int bcnt);
    bit done;
    done = 1'b0;
    bcnt = 0;
    for (int g = 0; g < 4000 && !done; g++) begin
      @(negedge clock);
      line_start = 1'b0;
      if (!busy) begin
        done = 1'b1;
      end else begin
        bcnt++;
        if (bcnt == ls1 || bcnt == ls2) line_start = 1'b1;
        if (bcnt == rst_at) begin
          reset = 1'b1;
          done  = 1'b1;
        end
      end
    end
    if (!done) chk("scan_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic scan_b(output int bc, output int pc,
                        output logic [31:0] cap);
    bit done;
    done = 1'b0;
    bc   = 0;
    pc   = 0;
    cap  = '0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clock);
      if (b_pixel_valid) begin
        if (pc < 32) cap[pc] = b_pixel;
        pc++;
      end
      if (!b_busy) done = 1'b1;
      else bc++;
    end
    if (!done) chk("b_scan_timeout", {31'b0, b_busy}, 32'h0);
  endtask

  initial begin
    int bc;
    int pc;
    logic [31:0] cap;
    reset        = 1'b1;
    word_data    = '0;
    word_valid   = 1'b0;
    line_start   = 1'b0;
    b_word_data  = '0;
    b_word_valid = 1'b0;
    b_line_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bm[0][i] = '0;
      bm[1][i] = '0;
    end
    fb  = 1'b0;
    fc  = 0;
    ff  = 1'b0;
    und = 1'b0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_ctrl",
        {23'b0, busy, pixel_valid, fill_full, word_ready, underrun,
         ram_ena, ram_enb, ram_web, ram_wea}, 32'h020);
    chk("reset_addra", {18'b0, ram_addra}, 32'h2000);
    chk("reset_addrb", {23'b0, ram_addrb}, 32'h0);
    chk("reset_b_ctrl",
        {28'b0, b_busy, b_fill_full, b_word_ready, b_underrun}, 32'h2);

    write_words(W + 1, 32'h0F3CA5F0);
    chk("fill_writes", 32'(wr_seen), 32'd20);
    chk("fill_full", {31'b0, fill_full}, 32'h1);
    chk("fill_ready", {31'b0, word_ready}, 32'h0);

    start_line();
    run_scan(0, 0, 0, bc);
    chk("l1_busy_cycles", 32'(bc), 32'd641);
    chk("l1_pixels", 32'(pix_seen - line_base), 32'd640);
    chk("l1_first32", first32, 32'h0F3CA5F0);
    chk("l1_addrb", {23'b0, ram_addrb}, 32'h100);
    chk("l1_flags", {29'b0, fill_full, word_ready, underrun}, 32'h2);

    write_words(5, 32'hA5A50000);
    start_line();
    run_scan(100, 641, 0, bc);
    chk("ur_busy_cycles", 32'(bc), 32'd641);
    chk("ur_pixels", 32'(pix_seen - line_base), 32'd640);
    chk("ur_first32", first32, 32'h0F3CA5F0);
    chk("ur_flags", {29'b0, fill_full, word_ready, underrun}, 32'h3);
    chk("ur_addrb", {23'b0, ram_addrb}, 32'h105);
    repeat (3) @(negedge clock);
    chk("ignored_start_idle", {31'b0, busy}, 32'h0);

    write_words(15, 32'h5A5A0005);
    chk("refill_full", {31'b0, fill_full}, 32'h1);
    start_line();
    run_scan(0, 0, 300, bc);
    #1;
    chk("rst_scan_flags",
        {27'b0, pixel_valid, busy, ram_ena, underrun, fill_full}, 32'h0);
    chk("rst_addrb", {23'b0, ram_addrb}, 32'h0);
    pq.delete();
    aq.delete();
    fb  = 1'b0;
    fc  = 0;
    ff  = 1'b0;
    und = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    write_words(2, 32'hC0DE0000);
    chk("post_rst_addrb", {23'b0, ram_addrb}, 32'h2);

    @(posedge clock); #1;
    b_word_valid = 1'b1;
    b_word_data  = 32'h80000001;
    #1;
    chk("b_w0_addrb", {23'b0, b_ram_addrb}, 32'h0);
    chk("b_w0_en", {30'b0, b_ram_enb, b_ram_web}, 32'h3);
    @(posedge clock); #1;
    b_word_valid = 1'b0;
    chk("b_full", {30'b0, b_fill_full, b_word_ready}, 32'h2);
    b_line_start = 1'b1;
    @(posedge clock); #1;
    b_line_start = 1'b0;
    scan_b(bc, pc, cap);
    chk("b_l1_busy", 32'(bc), 32'd33);
    chk("b_l1_pixels", 32'(pc), 32'd32);
    chk("b_l1_data", cap, 32'h80000001);
    chk("b_l1_flags", {30'b0, b_fill_full, b_underrun}, 32'h0);

    @(posedge clock); #1;
    b_line_start = 1'b1;
    b_word_valid = 1'b1;
    b_word_data  = 32'h12345678;
    #1;
    chk("b_w1_addrb", {23'b0, b_ram_addrb}, 32'h100);
    @(posedge clock); #1;
    b_line_start = 1'b0;
    b_word_valid = 1'b0;
    chk("b_ur_flags", {30'b0, b_fill_full, b_underrun}, 32'h3);
    scan_b(bc, pc, cap);
    chk("b_ur_busy", 32'(bc), 32'd33);
    chk("b_ur_pixels", 32'(pc), 32'd32);
    chk("b_ur_data", cap, 32'h80000001);

    repeat (3) @(negedge clock);
    chk("q_pixels_left", 32'(pq.size()), 32'd0);
    chk("q_reads_left", 32'(aq.size()), 32'd0);
    chk("q_writes_left", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
